clock_gate_ctrl: RTL
====================

CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NumCh, default 4: number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter IdleCycles, default 8: consecutive idle cycles before gating; 0 disables auto-gating (0..65535).
REQ-003 SHALL have ports:
- clk_i, input, 1: single free-running clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- test_en_i, input, 1: scan/test; forces every clk_o to follow clk_i.
- gate_en_i, input, 1: global auto-gating enable.
- busy_i, input, NumCh: per-channel activity.
- force_on_i, input, NumCh: per-channel keep-alive, treated as activity.
- wake_req_i, input, NumCh: per-channel wake request (level).
- wake_ack_o, output, NumCh: wake acknowledge (level).
- gated_o, output, NumCh: channel clock currently gated.
- clk_o, output, NumCh: gated clocks.

Function
REQ-004 Each channel SHALL run an independent FSM with states ON, DRAIN, OFF, WAKE and an idle counter of width $clog2(IdleCycles+1), minimum 1.
REQ-005 Activity SHALL be defined per channel as busy_i | force_on_i | wake_req_i | ~gate_en_i.
REQ-006 ON: if idle, go to DRAIN with cnt=1; if IdleCycles==1, go directly to OFF; else stay.
REQ-007 DRAIN: activity -> ON with cnt=0; idle and cnt==IdleCycles-1 -> OFF; else cnt+1.
REQ-008 Net effect: OFF SHALL be entered on the IdleCycles-th consecutive rising edge that samples the channel idle.
REQ-009 OFF: activity -> WAKE; else stay.
REQ-010 WAKE SHALL last exactly one cycle, then go to ON unconditionally.
REQ-011 The channel enable SHALL be a flop equal to (state != OFF), registered from the next-state logic.
REQ-012 Consequently, clk_o SHALL stop from the first clk_i high phase after the edge entering OFF, and resume from the first high phase after the edge entering WAKE.
REQ-013 clk_o[i] SHALL be produced glitch-free: the enable is captured in a latch transparent while clk_i is low, then ANDed with clk_i.
REQ-014 test_en_i SHALL OR into the latch input; it SHALL NOT alter FSM state, gated_o or wake_ack_o.
REQ-015 wake_ack_o[i] SHALL equal (state==ON) & wake_req_i[i].
REQ-016 Wake latency from OFF SHALL be: req sampled at edge N, WAKE after N, ON after N+1, ack high in the cycle after N+1.
REQ-017 If wake_req_i is already high in ON or DRAIN, ack SHALL be high in that cycle (ON) or after the next edge (DRAIN -> ON).
REQ-018 The requester SHALL hold wake_req_i until ack; dropping it during WAKE SHALL still complete to ON, after which normal idle counting resumes.
REQ-019 gated_o[i] SHALL be registered and equal 1 exactly while the state is OFF.
REQ-020 With IdleCycles==0, channels SHALL remain in ON permanently, gated_o=0, and ack SHALL follow wake_req_i combinationally.
REQ-021 Deasserting gate_en_i SHALL move DRAIN -> ON and OFF -> WAKE -> ON, identically for all channels on the same edges.
REQ-022 If activity and the terminal count occur in the same DRAIN cycle, activity SHALL win and the channel goes to ON.

Reset
REQ-023 While rst_ni=0, every channel SHALL be in ON with cnt=0, enable=1, gated_o=0 and wake_ack_o=0; clk_o SHALL follow clk_i.
REQ-024 Reset asserted mid-DRAIN, OFF or WAKE SHALL return the channel to ON asynchronously; the clock SHALL resume within one clk_i low phase, glitch-free.
REQ-025 After reset release, counting SHALL start from the first rising edge.

Structure
REQ-026 A shared package clock_gate_pkg SHALL hold the FSM state enum (cg_state_e) and the counter-width function.
REQ-027 The latch-plus-AND cell SHALL be a sub-module clock_gate_cell (clk_i, en_i, test_en_i, clk_o), instantiated NumCh times.
REQ-028 The FSM and counters SHALL be generated per channel within clock_gate_ctrl.
REQ-029 An elaboration-time assertion SHALL reject NumCh or IdleCycles outside their legal ranges.

Verification
REQ-030 All scenarios use NumCh=4 and IdleCycles=8.
REQ-031 Scenario 1: busy_i[0] drops at edge 10 and stays low -> gated_o[0]=1 after edge 17; clk_o[0] has no high pulse from edge 18; other channels unaffected.
REQ-032 Scenario 2: busy_i[1] low for 7 edges, high at the 8th -> channel 1 never gates and the counter restarts from 0.
REQ-033 Scenario 3: channel 2 in OFF, wake_req_i[2]=1 at edge N -> gated_o[2]=0 after N; first clk_o[2] pulse at edge N+1; wake_ack_o[2]=1 after N+1 until the request drops.
REQ-034 Scenario 4: test_en_i=1 with all channels OFF -> every clk_o toggles like clk_i while gated_o stays 4'b1111; test_en_i=0 -> clocks stop again without glitches.
REQ-035 Scenario 5: rst_ni pulsed low mid-clock-low while channel 3 is OFF -> gated_o[3]=0 immediately, clock restarts on the next high phase, and no runt pulse appears (checked with a pulse-width checker).
REQ-036 Scenario 6: gate_en_i=0 with all channels OFF -> all pass through WAKE and reach ON on the same two edges; gated_o=0 after the first edge.

Source files
------------

// File: rtl/clock_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_gate_pkg
// Description : Shared types and helpers for the per-channel clock gating
//               controller (channel FSM state and idle-counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_gate_pkg;

  // Per-channel gating state
  typedef enum logic [1:0] {
    CG_ON    = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  // Idle counter width: enough to hold IdleCycles, never narrower than 1 bit
  function automatic int unsigned cg_cnt_width(input int unsigned idle_cycles);
    int unsigned w;
    w = $clog2(idle_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_gate_cell.sv
`default_nettype none
// ============================================================================
// Module      : clock_gate_cell
// Description : Glitch-free clock gate: enable latched while clk_i is low,
//               then ANDed with clk_i. test_en_i forces the clock through.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_gate_cell (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_en_lat;

  // Capture the enable only while the clock is low so clk_o cannot chop a high phase
  always_latch begin
    if (!clk_i) begin
      r_en_lat <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & r_en_lat;

endmodule
`default_nettype wire

// File: rtl/clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_gate_ctrl
// Description : Per-channel idle-based clock gating controller. Each channel
//               counts consecutive idle cycles, gates its clock after
//               IdleCycles of them and wakes on any activity or wake request.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int NumCh      = 4,
  parameter int IdleCycles = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_en_i,
  input  logic             gate_en_i,
  input  logic [NumCh-1:0] busy_i,
  input  logic [NumCh-1:0] force_on_i,
  input  logic [NumCh-1:0] wake_req_i,
  output logic [NumCh-1:0] wake_ack_o,
  output logic [NumCh-1:0] gated_o,
  output logic [NumCh-1:0] clk_o
);

  localparam int unsigned     c_CNT_W = cg_cnt_width(IdleCycles);
  // Counter value seen on the last idle edge before entering OFF
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'((IdleCycles > 0) ? IdleCycles - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  // Reject illegal configurations at elaboration
  if (NumCh < 1 || NumCh > 32) begin : g_bad_numch
    $error("clock_gate_ctrl: NumCh must be within 1..32");
  end
  if (IdleCycles < 0 || IdleCycles > 65535) begin : g_bad_idle
    $error("clock_gate_ctrl: IdleCycles must be within 0..65535");
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    cg_state_e          r_state;
    cg_state_e          w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_en;
    logic               r_gated;
    logic               w_active;

    assign w_active = busy_i[g] | force_on_i[g] | wake_req_i[g] | ~gate_en_i;

    // Next-state and idle-counter logic; IdleCycles==0 pins the channel in ON
    always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (IdleCycles != 0) begin
        unique case (r_state)
          CG_ON: begin
            if (!w_active) begin
              if (IdleCycles == 1) begin
                w_next     = CG_OFF;
                w_cnt_next = '0;
              end else begin
                w_next     = CG_DRAIN;
                w_cnt_next = c_ONE;
              end
            end else begin
              w_cnt_next = '0;
            end
          end
          CG_DRAIN: begin
            // Activity takes priority over reaching the terminal count
            if (w_active) begin
              w_next     = CG_ON;
              w_cnt_next = '0;
            end else if (r_cnt == c_TERM) begin
              w_next     = CG_OFF;
              w_cnt_next = '0;
            end else begin
              w_cnt_next = r_cnt + c_ONE;
            end
          end
          CG_OFF: begin
            if (w_active) begin
              w_next = CG_WAKE;
            end
          end
          CG_WAKE: begin
            w_next     = CG_ON;
            w_cnt_next = '0;
          end
          default: begin
            w_next     = CG_ON;
            w_cnt_next = '0;
          end
        endcase
      end
    end

    // State, counter, clock enable and gated flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= CG_ON;
        r_cnt   <= '0;
        r_en    <= 1'b1;
        r_gated <= 1'b0;
      end else begin
        r_state <= w_next;
        r_cnt   <= w_cnt_next;
        r_en    <= (w_next != CG_OFF);
        r_gated <= (w_next == CG_OFF);
      end
    end

    // Acknowledge is held low throughout reset even if a request is pending
    assign wake_ack_o[g] = (r_state == CG_ON) & wake_req_i[g] & rst_ni;
    assign gated_o[g]    = r_gated;

    clock_gate_cell u_cell (
      .clk_i     (clk_i),
      .en_i      (r_en),
      .test_en_i (test_en_i),
      .clk_o     (clk_o[g])
    );
  end

endmodule
`default_nettype wire
